// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register. Each cycle it can capture one
// instruction from IF/ID and decode it into the ALU's alu_op/flag encoding.
// Supported instructions are ADD, SUB, OR, AND, MUL, ADDI, ORI and ANDI. It
// selects both ALU operands: register data, the sign-extended I-type
// immediate, and optional forwarded values. Every output is registered and
// drives the ALU directly.
//
// Per-edge priority: flush_i > stall_i > capture.
//   flush   : a bubble is loaded and illegal_o clears.
//   stall   : every output holds, including illegal_o.
//   capture : a legal instruction is loaded. An idle slot or an unsupported
//             encoding loads a bubble. An unsupported encoding also raises
//             illegal_o for one cycle.
//
// Configuration macro:
//   ID_EX_FWD_EN  defined   : rs1, and rs2 on R-type, are forwarded.
//                             The EX entry (alu_result_i) has priority over
//                             writeback (wb_*_i). x0 is never forwarded.
//                 undefined : operands come only from rs*_data_i and the
//                             immediate. The forwarding ports remain but are
//                             ignored.
//
// Ports:
//   clk_i, rst_i      clock; asynchronous active-high reset
//   valid_i           instr_i carries a real instruction
//   instr_i           instruction word
//   rs1_data_i        register-file read of instr_i[19:15]
//   rs2_data_i        register-file read of instr_i[24:20]
//   stall_i           hold all registered outputs
//   flush_i           replace the captured entry with a bubble
//   alu_result_i      result of the entry currently in EX (forward source 1)
//   wb_en_i           writeback enable (forward source 2)
//   wb_rd_i           writeback destination register
//   wb_data_i         writeback data
//   valid_o           EX entry is a real instruction
//   opr_1_o, opr_2_o  ALU operands
//   alu_op_o, flag_o  ALU operation select; flag_o=1 selects SUB
//   rd_o              destination register
//   reg_write_o       EX entry writes rd_o
//   illegal_o         one-cycle pulse: the dropped instruction was unsupported
// -----------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] alu_result_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        valid_o,
  output logic [31:0] opr_1_o,
  output logic [31:0] opr_2_o,
  output logic [3:0]  alu_op_o,
  output logic        flag_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        illegal_o
);

  // Opcode / funct encodings of the supported subset
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [2:0] F3Add    = 3'b000;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Sub    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;
  localparam logic [3:0] AluMul   = 4'b1000;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_idx;
  logic [31:0] imm_sext;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];
  assign rd_idx   = instr_i[11:7];
  assign imm_sext = {{20{instr_i[31]}}, instr_i[31:20]};

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       f3_alu_ok;
  logic       dec_legal;
  logic       dec_use_imm;
  logic       dec_flag;
  logic [3:0] dec_alu_op;

  // ADD/OR/AND share funct3 with ADDI/ORI/ANDI, and alu_op is {0, funct3}
  assign f3_alu_ok = (funct3 == F3Add) || (funct3 == F3Or) || (funct3 == F3And);

  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_flag    = 1'b0;
    dec_alu_op  = 4'b0000;
    case (opcode)
      OpcOpImm: begin
        if (f3_alu_ok) begin
          dec_legal   = 1'b1;
          dec_use_imm = 1'b1;
          dec_alu_op  = {1'b0, funct3};
        end
      end
      OpcOp: begin
        if ((funct7 == F7Base) && f3_alu_ok) begin
          dec_legal  = 1'b1;
          dec_alu_op = {1'b0, funct3};
        end else if ((funct7 == F7Sub) && (funct3 == F3Add)) begin
          dec_legal  = 1'b1;
          dec_flag   = 1'b1;
          dec_alu_op = 4'b0000;
        end else if ((funct7 == F7MulDiv) && (funct3 == F3Add)) begin
          dec_legal  = 1'b1;
          dec_alu_op = AluMul;
        end
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand sources
  // ---------------------------------------------------------------------------
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  // Registered EX state (declared here because forwarding reads it)
  logic        valid_q,     valid_d;
  logic [31:0] opr_1_q,     opr_1_d;
  logic [31:0] opr_2_q,     opr_2_d;
  logic [3:0]  alu_op_q,    alu_op_d;
  logic        flag_q,      flag_d;
  logic [4:0]  rd_q,        rd_d;
  logic        reg_write_q, reg_write_d;
  logic        illegal_q,   illegal_d;

`ifdef ID_EX_FWD_EN
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic       ex_can_fwd;
  logic       rs1_hit_ex, rs1_hit_wb;
  logic       rs2_hit_ex, rs2_hit_wb;

  assign rs1_idx = instr_i[19:15];
  assign rs2_idx = instr_i[24:20];

  // Uses the pre-edge EX entry, so back-to-back dependent ops need no stall
  assign ex_can_fwd = valid_q & reg_write_q;

  assign rs1_hit_ex = (rs1_idx != 5'd0) && ex_can_fwd && (rd_q == rs1_idx);
  assign rs1_hit_wb = (rs1_idx != 5'd0) && wb_en_i && (wb_rd_i == rs1_idx);
  assign rs2_hit_ex = (rs2_idx != 5'd0) && ex_can_fwd && (rd_q == rs2_idx);
  assign rs2_hit_wb = (rs2_idx != 5'd0) && wb_en_i && (wb_rd_i == rs2_idx);

  always_comb begin
    rs1_val = rs1_data_i;
    if (rs1_hit_ex) begin
      rs1_val = alu_result_i;
    end else if (rs1_hit_wb) begin
      rs1_val = wb_data_i;
    end
  end

  always_comb begin
    rs2_val = rs2_data_i;
    if (rs2_hit_ex) begin
      rs2_val = alu_result_i;
    end else if (rs2_hit_wb) begin
      rs2_val = wb_data_i;
    end
  end
`else
  // Without forwarding, hazards are resolved upstream. These inputs stay on the
  // port list but are deliberately ignored.
  logic unused_fwd;
  assign unused_fwd = ^{alu_result_i, wb_en_i, wb_rd_i, wb_data_i, instr_i[19:15]};

  assign rs1_val = rs1_data_i;
  assign rs2_val = rs2_data_i;
`endif

  // ---------------------------------------------------------------------------
  // Next-state: flush > stall > capture
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d     = valid_q;
    opr_1_d     = opr_1_q;
    opr_2_d     = opr_2_q;
    alu_op_d    = alu_op_q;
    flag_d      = flag_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;

    if (flush_i || !stall_i) begin
      // Bubble unless a legal instruction is captured below
      valid_d     = 1'b0;
      opr_1_d     = 32'd0;
      opr_2_d     = 32'd0;
      alu_op_d    = 4'b0000;
      flag_d      = 1'b0;
      rd_d        = 5'd0;
      reg_write_d = 1'b0;
      illegal_d   = 1'b0;

      if (!flush_i) begin
        illegal_d = valid_i & ~dec_legal;
        if (valid_i && dec_legal) begin
          valid_d     = 1'b1;
          opr_1_d     = rs1_val;
          opr_2_d     = dec_use_imm ? imm_sext : rs2_val;
          alu_op_d    = dec_alu_op;
          flag_d      = dec_flag;
          rd_d        = rd_idx;
          reg_write_d = (rd_idx != 5'd0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // EX register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      opr_1_q     <= 32'd0;
      opr_2_q     <= 32'd0;
      alu_op_q    <= 4'b0000;
      flag_q      <= 1'b0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      opr_1_q     <= opr_1_d;
      opr_2_q     <= opr_2_d;
      alu_op_q    <= alu_op_d;
      flag_q      <= flag_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign valid_o     = valid_q;
  assign opr_1_o     = opr_1_q;
  assign opr_2_o     = opr_2_q;
  assign alu_op_o    = alu_op_q;
  assign flag_o      = flag_q;
  assign rd_o        = rd_q;
  assign reg_write_o = reg_write_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// The bench has three parts:
//   - A table of decode vectors, each giving an input set and the expected
//     outputs.
//   - Hand-written multi-cycle sequences for forwarding, stall, flush and
//     reset.
//   - A randomized run checked against a behavioural model of the stage.
// Expected forwarding results depend on whether ID_EX_FWD_EN is defined.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  aluop;
    logic        flag;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } ex_t;

  typedef struct {
    logic        vld;
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    ex_t         e;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] alu_result_i;
  logic        wb_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        valid_o;
  logic [31:0] opr_1_o;
  logic [31:0] opr_2_o;
  logic [3:0]  alu_op_o;
  logic        flag_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;
  logic        illegal_o;

  int  n_vec  = 0;
  int  n_miss = 0;
  ex_t m;      // model's view of the EX entry
  vec_t tbl[$];

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .instr_i      (instr_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .alu_result_i (alu_result_i),
    .wb_en_i      (wb_en_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .valid_o      (valid_o),
    .opr_1_o      (opr_1_o),
    .opr_2_o      (opr_2_o),
    .alu_op_o     (alu_op_o),
    .flag_o       (flag_o),
    .rd_o         (rd_o),
    .reg_write_o  (reg_write_o),
    .illegal_o    (illegal_o)
  );

  // ---------------------------------------------------------------------------
  // Encoders
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic ex_t mk(input logic v, input logic [31:0] o1, input logic [31:0] o2,
                             input logic [3:0] op, input logic fl, input logic [4:0] rd,
                             input logic rw, input logic il);
    ex_t e;
    e.valid = v;  e.op1 = o1; e.op2 = o2; e.aluop = op;
    e.flag  = fl; e.rd  = rd; e.rw  = rw; e.ill   = il;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: classify by mnemonic, then look up the ALU encoding
  // ---------------------------------------------------------------------------
  localparam int KAdd = 0, KSub = 1, KOr = 2, KAnd = 3, KMul = 4;
  localparam int KAddi = 5, KOri = 6, KAndi = 7, KIll = 8;

  function automatic int classify(input logic [31:0] ins);
    logic [16:0] key_r;
    logic [9:0]  key_i;
    key_r = {ins[31:25], ins[14:12], ins[6:0]};
    key_i = {ins[14:12], ins[6:0]};
    if (key_r == {7'h00, 3'd0, 7'h33}) return KAdd;
    if (key_r == {7'h20, 3'd0, 7'h33}) return KSub;
    if (key_r == {7'h00, 3'd6, 7'h33}) return KOr;
    if (key_r == {7'h00, 3'd7, 7'h33}) return KAnd;
    if (key_r == {7'h01, 3'd0, 7'h33}) return KMul;
    if (key_i == {3'd0, 7'h13}) return KAddi;
    if (key_i == {3'd6, 7'h13}) return KOri;
    if (key_i == {3'd7, 7'h13}) return KAndi;
    return KIll;
  endfunction

  function automatic logic [3:0] alu_code(input int k);
    case (k)
      KOr, KOri:   return 4'd6;
      KAnd, KAndi: return 4'd7;
      KMul:        return 4'd8;
      default:     return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] fetch(input ex_t cur, input logic [4:0] rs,
                                        input logic [31:0] rf, input logic [31:0] ar,
                                        input logic wbe, input logic [4:0] wbr,
                                        input logic [31:0] wbd);
    if (!Fwd || rs == 5'd0) return rf;
    if (cur.valid && cur.rw && cur.rd == rs) return ar;
    if (wbe && wbr == rs) return wbd;
    return rf;
  endfunction

  function automatic ex_t model_next(input ex_t cur, input logic vld, input logic [31:0] ins,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     input logic st, input logic fl, input logic [31:0] ar,
                                     input logic wbe, input logic [4:0] wbr,
                                     input logic [31:0] wbd);
    ex_t n;
    int  k;
    n = '0;
    if (fl) return n;
    if (st) return cur;
    if (!vld) return n;
    k = classify(ins);
    if (k == KIll) begin
      n.ill = 1'b1;
      return n;
    end
    n.valid = 1'b1;
    n.rd    = ins[11:7];
    n.rw    = (ins[11:7] != 5'd0);
    n.aluop = alu_code(k);
    n.flag  = (k == KSub);
    n.op1   = fetch(cur, ins[19:15], r1, ar, wbe, wbr, wbd);
    if (k >= KAddi) n.op2 = {{20{ins[31]}}, ins[31:20]};
    else            n.op2 = fetch(cur, ins[24:20], r2, ar, wbe, wbr, wbd);
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Drive / check
  // ---------------------------------------------------------------------------
  task automatic apply(input logic vld, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic st, input logic fl,
                       input logic [31:0] ar, input logic wbe, input logic [4:0] wbr,
                       input logic [31:0] wbd);
    valid_i = vld; instr_i = ins; rs1_data_i = r1; rs2_data_i = r2;
    stall_i = st; flush_i = fl; alu_result_i = ar;
    wb_en_i = wbe; wb_rd_i = wbr; wb_data_i = wbd;
    m = model_next(m, vld, ins, r1, r2, st, fl, ar, wbe, wbr, wbd);
    @(posedge clk_i);
    #1;
  endtask

  // Plain capture: no stall, flush or writeback
  task automatic cap(input logic vld, input logic [31:0] ins, input logic [31:0] r1,
                     input logic [31:0] r2);
    apply(vld, ins, r1, r2, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic cmp(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  task automatic check(input string nm, input ex_t e);
    n_vec++;
    cmp(nm, "valid_o",     32'(valid_o),     32'(e.valid));
    cmp(nm, "opr_1_o",     opr_1_o,          e.op1);
    cmp(nm, "opr_2_o",     opr_2_o,          e.op2);
    cmp(nm, "alu_op_o",    32'(alu_op_o),    32'(e.aluop));
    cmp(nm, "flag_o",      32'(flag_o),      32'(e.flag));
    cmp(nm, "rd_o",        32'(rd_o),        32'(e.rd));
    cmp(nm, "reg_write_o", 32'(reg_write_o), 32'(e.rw));
    cmp(nm, "illegal_o",   32'(illegal_o),   32'(e.ill));
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    ex_t held;

    // Table entries are chained so that no entry forwards from its predecessor
    tbl.push_back(vec_t'{1'b1, enc_i(12'hFFD, 5'd0, 3'd0, 5'd5), 32'd0, 32'd0,
                  mk(1, 32'd0, 32'hFFFF_FFFD, 4'd0, 0, 5'd5, 1, 0)});          // addi x5,x0,-3
    tbl.push_back(vec_t'{1'b1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd10, 32'd4,
                  mk(1, 32'd10, 32'd4, 4'd0, 1, 5'd3, 1, 0)});                 // sub
    tbl.push_back(vec_t'{1'b1, enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd4), 32'd6, 32'd7,
                  mk(1, 32'd6, 32'd7, 4'd8, 0, 5'd4, 1, 0)});                  // mul
    tbl.push_back(vec_t'{1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd7), 32'hF0F0, 32'hFF00,
                  mk(1, 32'hF0F0, 32'hFF00, 4'd7, 0, 5'd7, 1, 0)});            // and
    tbl.push_back(vec_t'{1'b1, enc_i(12'h0F0, 5'd9, 3'd6, 5'd8), 32'h1234, 32'h5555,
                  mk(1, 32'h1234, 32'hF0, 4'd6, 0, 5'd8, 1, 0)});              // ori
    tbl.push_back(vec_t'{1'b1, enc_i(12'hFFF, 5'd1, 3'd7, 5'd0), 32'h77, 32'h0,
                  mk(1, 32'h77, 32'hFFFF_FFFF, 4'd7, 0, 5'd0, 0, 0)});         // andi x0
    tbl.push_back(vec_t'{1'b1, enc_r(7'h00, 5'd2, 5'd0, 3'd6, 5'd10), 32'h55, 32'hAA,
                  mk(1, 32'h55, 32'hAA, 4'd6, 0, 5'd10, 1, 0)});               // or
    tbl.push_back(vec_t'{1'b1, 32'h0000_0013, 32'd0, 32'd0,
                  mk(1, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 0)});                  // addi x0,x0,0
    tbl.push_back(vec_t'{1'b0, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd1, 32'd2,
                  mk(0, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 0)});                  // idle slot
    tbl.push_back(vec_t'{1'b1, 32'h0000_100B, 32'd1, 32'd2,
                  mk(0, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 1)});                  // custom opcode
    tbl.push_back(vec_t'{1'b0, 32'h0000_100B, 32'd1, 32'd2,
                  mk(0, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 0)});                  // pulse ends
    tbl.push_back(vec_t'{1'b1, enc_r(7'h20, 5'd2, 5'd1, 3'd6, 5'd3), 32'd1, 32'd2,
                  mk(0, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 1)});                  // bad funct7
    tbl.push_back(vec_t'{1'b1, enc_i(12'h001, 5'd1, 3'd1, 5'd1), 32'd1, 32'd2,
                  mk(0, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 1)});                  // slli
    tbl.push_back(vec_t'{1'b1, enc_r(7'h01, 5'd2, 5'd1, 3'd1, 5'd3), 32'd1, 32'd2,
                  mk(0, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 1)});                  // mulh
    tbl.push_back(vec_t'{1'b0, 32'h0000_100B, 32'd1, 32'd2,
                  mk(0, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 0)});                  // idle illegal
    tbl.push_back(vec_t'{1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd31), 32'hFFFF_FFFF, 32'd1,
                  mk(1, 32'hFFFF_FFFF, 32'd1, 4'd0, 0, 5'd31, 1, 0)});         // add x31
    tbl.push_back(vec_t'{1'b1, enc_i(12'h7FF, 5'd3, 3'd0, 5'd1), 32'd9, 32'd0,
                  mk(1, 32'd9, 32'h7FF, 4'd0, 0, 5'd1, 1, 0)});                // max +imm

    // Reset holds outputs at zero even with a valid instruction presented
    rst_i = 1'b1;
    valid_i = 1'b1; instr_i = enc_i(12'hFFD, 5'd0, 3'd0, 5'd5);
    rs1_data_i = 32'd0; rs2_data_i = 32'd0; stall_i = 1'b0; flush_i = 1'b0;
    alu_result_i = 32'd0; wb_en_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;
    m = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset", '0);
    rst_i = 1'b0;

    // Decode table
    for (int i = 0; i < tbl.size(); i++) begin
      cap(tbl[i].vld, tbl[i].instr, tbl[i].r1, tbl[i].r2);
      check($sformatf("tbl%0d", i), tbl[i].e);
    end

    // Forwarding: the EX entry beats writeback, x0 is never forwarded, and the
    // I-type rs2 field is never forwarded
    cap(1'b0, 32'd0, 32'd0, 32'd0);
    cap(1'b1, enc_i(12'hFFD, 5'd0, 3'd0, 5'd5), 32'd0, 32'd0);
    check("fwd_addi", mk(1, 32'd0, 32'hFFFF_FFFD, 4'd0, 0, 5'd5, 1, 0));
    apply(1'b1, enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6), 32'h11, 32'h11, 1'b0, 1'b0,
          32'hFFFF_FFFD, 1'b0, 5'd0, 32'd0);
    check("fwd_ex", mk(1, Fwd ? 32'hFFFF_FFFD : 32'h11, Fwd ? 32'hFFFF_FFFD : 32'h11,
                       4'd0, 0, 5'd6, 1, 0));
    apply(1'b1, enc_r(7'h00, 5'd6, 5'd9, 3'd0, 5'd7), 32'd1, 32'd2, 1'b0, 1'b0,
          32'hA5, 1'b1, 5'd9, 32'h99);
    check("fwd_wb", mk(1, Fwd ? 32'h99 : 32'd1, Fwd ? 32'hA5 : 32'd2, 4'd0, 0, 5'd7, 1, 0));
    apply(1'b1, enc_r(7'h00, 5'd3, 5'd7, 3'd0, 5'd8), 32'd1, 32'd2, 1'b0, 1'b0,
          32'hBB, 1'b1, 5'd7, 32'hCC);
    check("fwd_prio", mk(1, Fwd ? 32'hBB : 32'd1, 32'd2, 4'd0, 0, 5'd8, 1, 0));
    apply(1'b1, enc_r(7'h00, 5'd0, 5'd0, 3'd6, 5'd9), 32'h21, 32'h22, 1'b0, 1'b0,
          32'hBB, 1'b1, 5'd0, 32'd7);
    check("fwd_x0", mk(1, 32'h21, 32'h22, 4'd6, 0, 5'd9, 1, 0));
    apply(1'b1, enc_i(12'h009, 5'd1, 3'd0, 5'd10), 32'h3, 32'h4, 1'b0, 1'b0,
          32'h1234, 1'b1, 5'd9, 32'h5678);
    check("fwd_imm", mk(1, 32'h3, 32'h9, 4'd0, 0, 5'd10, 1, 0));

    // Stall holds outputs for 3 cycles while the inputs keep changing
    cap(1'b0, 32'd0, 32'd0, 32'd0);
    cap(1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd12), 32'd3, 32'd5);
    held = mk(1, 32'd3, 32'd5, 4'd6, 0, 5'd12, 1, 0);
    check("stall_cap", held);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, enc_r(7'h01, 5'd4, 5'd3, 3'd0, 5'(20 + i)), $urandom, $urandom, 1'b1, 1'b0,
            $urandom, 1'b1, 5'd3, $urandom);
      check($sformatf("stall%0d", i), held);
    end
    // The stalled-over instruction was not consumed: release captures new input
    cap(1'b1, enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd13), 32'd8, 32'd9);
    check("stall_rel", mk(1, 32'd8, 32'd9, 4'd8, 0, 5'd13, 1, 0));

    // A stall holds illegal_o too
    cap(1'b1, 32'h0000_100B, 32'd0, 32'd0);
    check("ill_cap", mk(0, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 1));
    apply(1'b1, 32'h0000_0013, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("ill_stall", mk(0, 32'd0, 32'd0, 4'd0, 0, 5'd0, 0, 1));
    cap(1'b0, 32'd0, 32'd0, 32'd0);
    check("ill_end", '0);

    // Flush wins over stall
    cap(1'b1, enc_i(12'h123, 5'd1, 3'd7, 5'd14), 32'hFF, 32'd0);
    check("fl_cap", mk(1, 32'hFF, 32'h123, 4'd7, 0, 5'd14, 1, 0));
    apply(1'b1, enc_i(12'h001, 5'd1, 3'd0, 5'd15), 32'd1, 32'd1, 1'b1, 1'b1,
          32'd0, 1'b0, 5'd0, 32'd0);
    check("stall_flush", '0);
    // Flush also drops an illegal pulse
    cap(1'b1, 32'h0000_100B, 32'd0, 32'd0);
    apply(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 5'd0, 32'd0);
    check("flush_ill", '0);

    // Asynchronous reset clears the entry between edges
    cap(1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd11), 32'd5, 32'd6);
    check("arst_cap", mk(1, 32'd5, 32'd6, 4'd0, 0, 5'd11, 1, 0));
    #2 rst_i = 1'b1;
    #1 check("arst", '0);
    #2 rst_i = 1'b0;
    m = '0;

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [4:0]  a, b, d;
      a = 5'($urandom_range(0, 7));
      b = 5'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: ins = enc_r(7'h00, b, a, 3'd0, d);
        1: ins = enc_r(7'h20, b, a, 3'd0, d);
        2: ins = enc_r(7'h00, b, a, 3'd6, d);
        3: ins = enc_r(7'h00, b, a, 3'd7, d);
        4: ins = enc_r(7'h01, b, a, 3'd0, d);
        5: ins = enc_i(12'($urandom), a, 3'd0, d);
        6: ins = enc_i(12'($urandom), a, 3'd6, d);
        7: ins = enc_i(12'($urandom), a, 3'd7, d);
        8: ins = $urandom;
        default: ins = enc_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h01, b, a,
                             3'($urandom_range(0, 7)), d);
      endcase
      apply($urandom_range(0, 7) != 0, ins, $urandom, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom,
            $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom);
      check($sformatf("rnd%0d", i), m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
